// File: rtl/foo_pkg.sv
// Shared widths and the entry type used by the foo receiver-side inverse datapath.
package foo_pkg;

  localparam int unsigned FOO_W      = 64;
  localparam int unsigned FOO_LONG_W = 129;

  typedef logic [FOO_W-1:0]      foo_word_t;
  typedef logic [FOO_LONG_W-1:0] foo_long_t;

  typedef struct packed {
    foo_word_t a;
    foo_long_t long_bus;
  } foo_unaccum_entry_t;

endpackage

// File: rtl/foo_unaccum_if.sv
// Sample-in / result-out streams of foo_unaccum. The master drives samples and consumes results.
interface foo_unaccum_if;
  import foo_pkg::*;

  logic      in_valid;
  logic      in_ready;
  foo_word_t in_x;
  foo_long_t in_long;
  logic      out_valid;
  logic      out_ready;
  foo_word_t out_a;
  foo_long_t out_long;

  modport master (
    output in_valid, in_x, in_long, out_ready,
    input  in_ready, out_valid, out_a, out_long
  );

  modport slave (
    input  in_valid, in_x, in_long, out_ready,
    output in_ready, out_valid, out_a, out_long
  );

endinterface

// File: rtl/foo_unaccum_fifo.sv
// First-word fall-through FIFO: a pushed entry becomes visible at the head on the next cycle.
module foo_unaccum_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/foo_unaccum.sv
// Recovers the per-sample increment a from accumulator samples x (x = prev + a + 1)
// and re-inverts the companion bus, queuing results in an output FIFO.
module foo_unaccum
  import foo_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned PRIME_ON_FIRST = 0,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  foo_unaccum_if.slave     bus,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             overflow_err
);

  foo_word_t          prev_q, prev_d;
  logic               primed_q, primed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  foo_word_t          diff;
  logic               full, empty;
  logic               accept, push, pop, hold_back;
  foo_unaccum_entry_t push_entry, head;

  assign accept     = bus.in_valid && !full;
  assign hold_back  = (PRIME_ON_FIRST != 0) && !primed_q;
  assign push       = accept && !hold_back;
  assign pop        = bus.out_valid && bus.out_ready;
  assign diff       = bus.in_x - prev_q - 64'd1;
  assign push_entry = '{a: diff, long_bus: ~bus.in_long};

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_a     = head.a;
  assign bus.out_long  = head.long_bus;
  assign sample_cnt    = cnt_q;
  assign overflow_err  = err_q;

  always_comb begin
    prev_d   = prev_q;
    primed_d = primed_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (accept) begin
      prev_d   = bus.in_x;
      primed_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
    // All-ones diff means the encoder saw x == prev, i.e. a wrapped to -1.
    if (push && (diff == {FOO_W{1'b1}})) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  foo_unaccum_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (foo_unaccum_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_foo_unaccum.sv
// Directed bench for foo_unaccum: queue-based reference model checked every cycle plus literal expectations.
module tb_foo_unaccum;
  import foo_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cnt, pcnt;
  logic        err, perr;

  always #5 clk = ~clk;

  foo_unaccum_if bus ();
  foo_unaccum_if pbus ();

  foo_unaccum #(.DEPTH(DEPTH), .PRIME_ON_FIRST(0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sample_cnt(cnt), .overflow_err(err)
  );

  foo_unaccum #(.DEPTH(DEPTH), .PRIME_ON_FIRST(1), .CNT_W(32)) u_prime (
    .clk(clk), .rst(rst), .bus(pbus), .sample_cnt(pcnt), .overflow_err(perr)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state (main instance)
  foo_unaccum_entry_t mq[$];
  foo_word_t          m_prev;
  logic [31:0]        m_cnt;
  logic               m_err;
  foo_word_t          obs[$];
  int                 acc_cnt;
  logic               pv_valid, pv_in_ready;
  foo_word_t          pv_a;
  bit                 take, give;
  foo_word_t          d;

  localparam foo_long_t L_ERR     = 129'h1_0000_0000_0000_0000_0000_0000_0000_00FF;
  localparam foo_long_t L_ERR_INV = 129'h0_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00;

  task automatic check(input string nm, input logic [128:0] act, input logic [128:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic take_obs(input string nm, input foo_word_t exp);
    if (obs.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no output popped, expected %h", nm, exp);
    end else begin
      check(nm, obs.pop_front(), exp);
    end
  endtask

  // One cycle of stimulus; inputs change just after the falling edge.
  task automatic drive(input logic v, input foo_word_t x, input foo_long_t l, input logic r);
    @(negedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_x      = x;
    bus.in_long   = l;
    bus.out_ready = r;
    $display("[TB] t=%0t drive valid=%0b x=%h out_ready=%0b", $time, v, x, r);
  endtask

  task automatic pdrive(input logic v, input foo_word_t x);
    @(negedge clk);
    #1;
    pbus.in_valid = v;
    pbus.in_x     = x;
    $display("[TB] t=%0t prime-drive valid=%0b x=%0d", $time, v, x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Per-cycle compare: update the model with the inputs sampled at the last rising edge,
  // then check the DUT against it.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && pv_valid && bus.out_ready) obs.push_back(pv_a);
      if (!rst && pv_in_ready && bus.in_valid) acc_cnt++;
      if (rst) begin
        mq.delete();
        m_prev = '0;
        m_cnt  = '0;
        m_err  = 1'b0;
      end else begin
        take = bus.in_valid && (mq.size() < DEPTH);
        give = bus.out_ready && (mq.size() > 0);
        d    = bus.in_x - m_prev - 1;
        if (give) void'(mq.pop_front());
        if (take) begin
          mq.push_back('{a: d, long_bus: ~bus.in_long});
          m_prev = bus.in_x;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
          if (d == 64'hFFFF_FFFF_FFFF_FFFF) m_err = 1'b1;
        end
      end
      check("in_ready", bus.in_ready, mq.size() < DEPTH);
      check("out_valid", bus.out_valid, mq.size() > 0);
      check("sample_cnt", cnt, m_cnt);
      check("overflow_err", err, m_err);
      if (mq.size() > 0) begin
        check("out_a", bus.out_a, mq[0].a);
        check("out_long", bus.out_long, mq[0].long_bus);
      end
      pv_valid    = bus.out_valid;
      pv_a        = bus.out_a;
      pv_in_ready = bus.in_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_x       = '0;
    bus.in_long    = '0;
    bus.out_ready  = 1'b1;
    pbus.in_valid  = 1'b0;
    pbus.in_x      = '0;
    pbus.in_long   = '0;
    pbus.out_ready = 1'b1;
    acc_cnt        = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_cnt", cnt, 0);
    rst = 1'b0;

    // Basic recovery
    drive(1, 64'd1, 129'h3, 1);
    drive(1, 64'd3, 129'h5, 1);
    drive(1, 64'd6, 129'h7, 1);
    repeat (3) drive(0, 0, 0, 1);
    take_obs("basic_a0", 64'd0);
    take_obs("basic_a1", 64'd1);
    take_obs("basic_a2", 64'd2);
    check("basic_cnt", cnt, 3);

    // Wrap-around
    do_reset();
    obs.delete();
    drive(1, 64'hFFFF_FFFF_FFFF_FFFE, 129'h0, 1);
    drive(1, 64'h0000_0000_0000_0005, 129'h0, 1);
    repeat (3) drive(0, 0, 0, 1);
    take_obs("wrap_a0", 64'hFFFF_FFFF_FFFF_FFFD);
    take_obs("wrap_a1", 64'd6);

    // Backpressure: six offers into a four-entry FIFO with the consumer stalled
    do_reset();
    obs.delete();
    acc_cnt = 0;
    drive(1, 64'd10, 129'h1, 0);
    drive(1, 64'd21, 129'h2, 0);
    drive(1, 64'd33, 129'h3, 0);
    drive(1, 64'd46, 129'h4, 0);
    drive(1, 64'd60, 129'h5, 0);
    drive(1, 64'd75, 129'h6, 0);
    drive(0, 0, 0, 0);
    @(posedge clk); #1;
    check("bp_full_ready", bus.in_ready, 1'b0);
    drive(0, 0, 0, 1);
    @(posedge clk); #1;
    check("bp_ready_after_pop", bus.in_ready, 1'b1);
    repeat (5) drive(0, 0, 0, 1);
    check("bp_accepts", acc_cnt, 4);
    take_obs("bp_a0", 64'd9);
    take_obs("bp_a1", 64'd10);
    take_obs("bp_a2", 64'd11);
    take_obs("bp_a3", 64'd12);

    // Priming instance: first sample only loads the baseline
    do_reset();
    drive(0, 0, 0, 1);
    pdrive(1, 64'd100);
    @(posedge clk); #1;
    check("prime_no_out", pbus.out_valid, 1'b0);
    pdrive(1, 64'd150);
    @(posedge clk); #1;
    check("prime_valid", pbus.out_valid, 1'b1);
    check("prime_a", pbus.out_a, 64'd49);
    pdrive(0, 0);
    @(posedge clk); #1;
    check("prime_cnt", pcnt, 2);
    check("prime_drained", pbus.out_valid, 1'b0);

    // Companion bus and sticky overflow
    do_reset();
    obs.delete();
    drive(1, 64'd7, L_ERR, 1);
    @(posedge clk); #1;
    check("long_inv", bus.out_long, L_ERR_INV);
    drive(1, 64'd7, L_ERR, 1);
    drive(1, 64'd10, L_ERR, 1);
    repeat (3) drive(0, 0, 0, 1);
    take_obs("err_a0", 64'd6);
    take_obs("err_a1", 64'hFFFF_FFFF_FFFF_FFFF);
    take_obs("err_a2", 64'd2);
    check("err_sticky", err, 1'b1);

    // Mid-stream reset with three entries queued
    do_reset();
    obs.delete();
    drive(1, 64'd1, 129'h0, 0);
    drive(1, 64'd2, 129'h0, 0);
    drive(1, 64'd3, 129'h0, 0);
    @(negedge clk); #1;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_x     = 64'd99;
    @(posedge clk); #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_cnt", cnt, 0);
    check("rst_err", err, 1'b0);
    @(negedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    drive(1, 64'd5, 129'h0, 1);
    repeat (3) drive(0, 0, 0, 1);
    take_obs("post_rst_a", 64'd4);
    check("post_rst_cnt", cnt, 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/foo_unaccum.md
Name: foo_unaccum

Overview:
- Receiver-side inverse of the foo accumulator datapath.
- Consumes the stream of accumulator samples x, where each x is the previous x plus a plus 1 (mod 2^64), and recovers the original increment a per sample.
- Re-inverts the 129-bit companion bus back to its original sense.
- Buffers results in a small FIFO with valid/ready handshakes on both sides, so it can sit between the foo model and a checker or host DPI consumer.

Parameters:
DEPTH, 4, output FIFO entries; power of two, 2..16
PRIME_ON_FIRST, 0, 1 = first accepted sample after reset only loads the baseline and produces no output
CNT_W, 32, width of the accepted-sample counter

Ports:
clk  input  1  sole clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
in_valid  input  1  sample present
in_ready  output  1  block can accept a sample this cycle
in_x  input  64  accumulator sample
in_long  input  129  inverted companion bus
out_valid  output  1  recovered result available at FIFO head
out_ready  input  1  consumer takes head this cycle
out_a  output  64  recovered increment
out_long  output  129  re-inverted companion bus (~in_long)
sample_cnt  output  CNT_W  accepted samples since reset, saturating
overflow_err  output  1  sticky; set when any recovered a equals all-ones (x == prev)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - prev_q = 0 (matches the encoder power-up accumulator value).
  - FIFO empty, so out_valid = 0 and in_ready = 1.
  - sample_cnt = 0, overflow_err = 0, primed_q = 0.
  - out_a and out_long are don't-care while out_valid = 0; the bench must not check them then.
- Reset mid-operation: FIFO contents are discarded, all state returns to reset values, and no handshake completes in the reset cycle.
- Input handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = !full. It is a function of registered occupancy only; there is no full-and-pop bypass.
  - in_x and in_long may change freely while in_ready = 0.
- On each accept:
  - diff = in_x - prev_q - 1, modulo 2^64 (wrap-around is legal).
  - prev_q <= in_x.
  - sample_cnt increments and saturates at all-ones.
- Priming, when PRIME_ON_FIRST = 1:
  - While primed_q = 0, an accept updates prev_q, sets primed_q, increments sample_cnt, and pushes nothing to the FIFO.
  - While primed_q = 1, every accept pushes.
  - When PRIME_ON_FIRST = 0, every accept pushes.
- Push contents: the entry {diff, ~in_long}. If diff == 64'hFFFF_FFFF_FFFF_FFFF, set overflow_err; it stays set until rst.
- Latency: a sample accepted in cycle N is visible at out_valid/out_a in cycle N+1 at the earliest (registered FIFO, first-word fall-through).
- Output handshake:
  - A pop occurs when out_valid && out_ready.
  - out_valid = !empty.
  - Head data is held stable while out_valid && !out_ready.
- Simultaneous push and pop when non-empty and non-full: occupancy unchanged, order preserved.
- Push when empty and pop in the same cycle: cannot occur (out_valid = 0), so the entry lands and becomes head next cycle.
- Full: in_ready = 0 for the whole cycle, even if out_ready = 1. in_ready returns to 1 in the cycle after a pop.
- Occupancy counter width is $clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- No state machine beyond primed_q: IDLE (unprimed) goes to RUN on the first accept; RUN goes back to IDLE only on rst.

Decomposition:
- foo_pkg holds:
  - FOO_W = 64 and FOO_LONG_W = 129.
  - typedef foo_word_t = logic [FOO_W-1:0].
  - typedef foo_long_t = logic [FOO_LONG_W-1:0].
  - typedef struct packed {foo_word_t a; foo_long_t long_bus;} foo_unaccum_entry_t.
- One sub-module, foo_unaccum_fifo: parameterised on DEPTH and entry type, with synchronous active-high reset, push/pop/full/empty and first-word fall-through.
- The difference logic, priming, counter and error flag live in the top.

Test Plan:
- Basic recovery: rst, then accept in_x = 1, 3, 6 with out_ready = 1.
  -> out_a = 0, 1, 2, each one cycle after its accept; sample_cnt = 3.
- Wrap-around: accept in_x = 64'hFFFF_FFFF_FFFF_FFFE, then in_x = 64'h0000_0000_0000_0005.
  -> second out_a = 6 (the first is 64'hFFFF_FFFF_FFFF_FFFD).
- Backpressure with DEPTH = 4 and out_ready = 0: offer 6 samples.
  -> exactly 4 accepted; in_ready = 0 from the cycle after the 4th accept.
  -> raising out_ready then drains all 4 in order, and in_ready = 1 the cycle after the first pop.
- Priming with PRIME_ON_FIRST = 1: accept 100, then 150.
  -> no output for the first; one output out_a = 49; sample_cnt = 2.
- Companion bus and error: in_long = 129'h1_0000_0000_0000_0000_0000_0000_0000_00FF with repeated in_x = 7 (after 7).
  -> out_long = ~in_long, out_a = all-ones, overflow_err = 1 and it stays set.
- Mid-stream reset: assert rst for 1 cycle with 3 entries queued.
  -> next cycle out_valid = 0, in_ready = 1, sample_cnt = 0.
  -> a following in_x = 5 yields out_a = 4.
